// File: rtl/menu_keyboard_decoder.sv
// PS/2 keyboard receiver and scan-code decoder producing menu key pulses.
// Keys: [0]=up (E0 75), [1]=down (E0 72), [2]=enter (5A), [3]=escape (76).
module menu_keyboard_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keyboard_out,
  output logic [3:0] key_held,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  logic          clk_s1;
  logic          clk_s2;
  logic          dat_s1;
  logic          dat_s2;
  logic          filt;
  logic          filt_d;
  logic [FW-1:0] fcnt;
  logic          fall;

  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] tcnt;
  logic          frame_ok;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  state_t        state;
  state_t        state_nx;
  logic          make;
  logic          brk;
  logic          ext;
  logic [3:0]    key_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      filt_d <= filt;
      if (clk_s2 != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= clk_s2;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // shift[0]=start, shift[8:1]=data, shift[9]=parity; dat_s2 is the stop bit
  assign frame_ok = ~shift[0] & (^shift[9:1]) & dat_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift   <= {dat_s2, shift[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt <= '0;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    make     = 1'b0;
    brk      = 1'b0;
    ext      = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_nx = EXT;
          else if (rx_byte == 8'hF0) state_nx = BRK;
          else                       make     = 1'b1;
        end
        EXT: begin
          if (rx_byte == 8'hF0) begin
            state_nx = EXT_BRK;
          end else if (rx_byte != 8'hE0) begin
            state_nx = IDLE;
            make     = 1'b1;
            ext      = 1'b1;
          end
        end
        BRK: begin
          if (rx_byte != 8'hF0) begin
            state_nx = IDLE;
            brk      = 1'b1;
          end
        end
        EXT_BRK: begin
          if (rx_byte != 8'hF0) begin
            state_nx = IDLE;
            brk      = 1'b1;
            ext      = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    key_mask = 4'b0000;
    if (ext) begin
      if (rx_byte == 8'h75)      key_mask = 4'b0001;
      else if (rx_byte == 8'h72) key_mask = 4'b0010;
    end else begin
      if (rx_byte == 8'h5A)      key_mask = 4'b0100;
      else if (rx_byte == 8'h76) key_mask = 4'b1000;
    end
  end

  // key_mask is one-hot or zero, so at most one pulse bit is ever set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyboard_out <= '0;
      key_held     <= '0;
    end else begin
      keyboard_out <= make ? (key_mask & ~key_held) : 4'b0000;
      if (make)     key_held <= key_held | key_mask;
      else if (brk) key_held <= key_held & ~key_mask;
    end
  end

endmodule

// File: tb/tb_menu_keyboard_decoder.sv
// Scoreboard bench for menu_keyboard_decoder: PS/2 frames in, key pulses,
// held levels and frame errors checked against hand-computed expectations.
module tb_menu_keyboard_decoder;

  localparam int FL = 8;
  localparam int TO = 2000;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyboard_out;
  logic [3:0] key_held;
  logic       frame_err;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  menu_keyboard_decoder #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keyboard_out(keyboard_out),
    .key_held(key_held),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // kind 1 = key pulse, kind 2 = frame error
  always @(negedge clk) begin
    if (!rst && (keyboard_out != 4'b0000 || frame_err)) begin
      exp_t e;
      int   k;
      k = frame_err ? 2 : 1;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kbd=%b err=%b cyc=%0d",
                 keyboard_out, frame_err, cyc);
      end else begin
        e = q.pop_front();
        if (k != e.kind || (k == 1 && keyboard_out !== e.val) ||
            (k == 2 && keyboard_out !== 4'b0000) || cyc != e.at) begin
          errors++;
          $display("FAIL event kind=%0d kbd=%b cyc=%0d expected kind=%0d kbd=%b cyc=%0d",
                   k, keyboard_out, cyc, e.kind, e.val, e.at);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par,
                            input int nbits, input int kind,
                            input logic [3:0] val, input bit glitch);
    logic [10:0] f;
    exp_t        e;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(20);
      if (glitch && i == 3) begin
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(10);
      end
      ps2_clk = 1'b0;
      if (i == 10 && kind != 0) begin
        e.kind = kind;
        e.val  = val;
        e.at   = cyc + ((kind == 1) ? 12 : 11);
        q.push_back(e);
      end
      wait_cyc(40);
      if (glitch && i == 3) begin
        ps2_clk = 1'b1;
        wait_cyc(3);
        ps2_clk = 1'b0;
        wait_cyc(10);
      end
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
    wait_cyc(30);
  endtask

  task automatic send(input logic [7:0] d, input int kind,
                      input logic [3:0] val);
    send_frame(d, 1'b0, 11, kind, val, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("reset_kbd", keyboard_out, 4'b0000);
    chk("reset_held", key_held, 4'b0000);
    chk("reset_err", {3'b000, frame_err}, 4'b0000);
    rst = 1'b0;
    wait_cyc(10);

    send(8'h5A, 1, 4'b0100);
    chk("enter_make_held", key_held, 4'b0100);
    send(8'hF0, 0, 4'b0000);
    send(8'h5A, 0, 4'b0000);
    chk("enter_break_held", key_held, 4'b0000);

    send(8'hE0, 0, 4'b0000);
    send(8'h75, 1, 4'b0001);
    for (int r = 0; r < 2; r++) begin
      send(8'hE0, 0, 4'b0000);
      send(8'h75, 0, 4'b0000);
    end
    chk("up_repeat_held", key_held, 4'b0001);
    send(8'hE0, 0, 4'b0000);
    send(8'hF0, 0, 4'b0000);
    chk("up_mid_break_held", key_held, 4'b0001);
    send(8'h75, 0, 4'b0000);
    chk("up_break_held", key_held, 4'b0000);

    send_frame(8'h76, 1'b1, 11, 2, 4'b0000, 1'b0);
    chk("bad_parity_held", key_held, 4'b0000);
    send(8'h76, 1, 4'b1000);
    chk("esc_held", key_held, 4'b1000);

    send_frame(8'h12, 1'b0, 4, 0, 4'b0000, 1'b0);
    wait_cyc(TO + 1000);
    send(8'hE0, 0, 4'b0000);
    send(8'h72, 1, 4'b0010);
    chk("down_after_timeout_held", key_held, 4'b1010);

    send_frame(8'h5A, 1'b0, 11, 1, 4'b0100, 1'b1);
    chk("glitch_enter_held", key_held, 4'b1110);

    send_frame(8'h5A, 1'b0, 6, 0, 4'b0000, 1'b0);
    rst = 1'b1;
    wait_cyc(5);
    chk("midreset_kbd", keyboard_out, 4'b0000);
    chk("midreset_held", key_held, 4'b0000);
    rst = 1'b0;
    wait_cyc(10);
    send(8'h76, 1, 4'b1000);
    chk("after_reset_held", key_held, 4'b1000);

    wait_cyc(50);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
